// File: rtl/cam_pwr_pkg.sv
// Shared types and default timing for the camera power sequencer.
package cam_pwr_pkg;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_PWDN   = 3'd1,
    S_RST    = 3'd2,
    S_SETTLE = 3'd3,
    S_ON     = 3'd4
  } pwr_state_e;

  // Default phase lengths (in clock cycles) used by the ov5640 shell.
  localparam int unsigned OV5640_PWDN_CYC   = 1_000_000;
  localparam int unsigned OV5640_RST_CYC    = 100_000;
  localparam int unsigned OV5640_SETTLE_CYC = 2_000_000;

endpackage

// File: rtl/cam_pwr_timer.sv
// Loadable down-counter that parks at zero and flags it.
module cam_pwr_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear beats load; otherwise count down and hold at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: PWDN hold, reset hold, settle, then on.
module cam_pwr_seq
  import cam_pwr_pkg::*;
#(
  parameter int          NUM_CAM    = 1,
  parameter int          CNT_W      = 32,
  parameter int unsigned PWDN_CYC   = OV5640_PWDN_CYC,
  parameter int unsigned RST_CYC    = OV5640_RST_CYC,
  parameter int unsigned SETTLE_CYC = OV5640_SETTLE_CYC,
  parameter int          AUTO_START = 1
) (
  input  logic               s_axil_aclk,
  input  logic               s_axil_arst_n,
  input  logic               seq_start,
  input  logic               seq_pwdn_req,
  input  logic [NUM_CAM-1:0] cam_en,
  output logic [NUM_CAM-1:0] cam_pwdn,
  output logic [NUM_CAM-1:0] cam_rst_n,
  output logic               seq_busy,
  output logic               seq_done
);

  // Cycle parameters are 32-bit, so any CNT_W above 32 holds every legal value.
  localparam logic [63:0] CNT_LIM = (CNT_W >= 33) ? 64'h1_0000_0000 : (64'd1 << CNT_W);

  if (NUM_CAM < 1 || NUM_CAM > 8) begin : g_bad_num_cam
    $error("cam_pwr_seq: NUM_CAM must be 1..8");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cam_pwr_seq: CNT_W must be at least 1");
  end
  if (PWDN_CYC < 1 || 64'(PWDN_CYC) >= CNT_LIM) begin : g_bad_pwdn
    $error("cam_pwr_seq: PWDN_CYC out of range");
  end
  if (RST_CYC < 1 || 64'(RST_CYC) >= CNT_LIM) begin : g_bad_rst
    $error("cam_pwr_seq: RST_CYC out of range");
  end
  if (SETTLE_CYC < 1 || 64'(SETTLE_CYC) >= CNT_LIM) begin : g_bad_settle
    $error("cam_pwr_seq: SETTLE_CYC out of range");
  end
  if (AUTO_START != 0 && AUTO_START != 1) begin : g_bad_auto
    $error("cam_pwr_seq: AUTO_START must be 0 or 1");
  end

  localparam logic [CNT_W-1:0]   PWDN_LOAD   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [NUM_CAM-1:0] MASK_ALL    = {NUM_CAM{1'b1}};

  pwr_state_e         state_q;
  pwr_state_e         state_d;
  logic [NUM_CAM-1:0] mask_q;
  logic [NUM_CAM-1:0] mask_d;
  logic               auto_q;
  logic               start_req;
  logic [NUM_CAM-1:0] start_en;
  logic               tmr_load;
  logic               tmr_clear;
  logic               tmr_zero;
  logic [CNT_W-1:0]   tmr_val;

  // The auto-start pending flag acts as a start with every channel enabled.
  assign start_req = seq_start | auto_q;
  assign start_en  = auto_q ? MASK_ALL : cam_en;

  cam_pwr_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (s_axil_aclk),
    .rst_ni     (s_axil_arst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .clear_i    (tmr_clear),
    .zero_o     (tmr_zero)
  );

  // Next state, timer control and the output decode of state plus mask.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = '0;
    cam_pwdn  = MASK_ALL;
    cam_rst_n = '0;
    seq_busy  = 1'b0;
    seq_done  = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (start_req && !seq_pwdn_req && (start_en != '0)) begin
          state_d  = S_PWDN;
          mask_d   = start_en;
          tmr_load = 1'b1;
          tmr_val  = PWDN_LOAD;
        end
      end
      S_PWDN: begin
        seq_busy = 1'b1;
        if (tmr_zero) begin
          state_d  = S_RST;
          tmr_load = 1'b1;
          tmr_val  = RST_LOAD;
        end
      end
      S_RST: begin
        seq_busy = 1'b1;
        cam_pwdn = ~mask_q;
        if (tmr_zero) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        seq_busy  = 1'b1;
        cam_pwdn  = ~mask_q;
        cam_rst_n = mask_q;
        if (tmr_zero) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        seq_done  = 1'b1;
        cam_pwdn  = ~mask_q;
        cam_rst_n = mask_q;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (seq_pwdn_req && (state_q != S_OFF)) begin
      state_d   = S_OFF;
      mask_d    = '0;
      tmr_load  = 1'b0;
      tmr_clear = 1'b1;
    end
  end

  // State, mask and one-shot auto-start registers.
  always_ff @(posedge s_axil_aclk or negedge s_axil_arst_n) begin
    if (!s_axil_arst_n) begin
      state_q <= S_OFF;
      mask_q  <= '0;
      auto_q  <= (AUTO_START != 0);
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      auto_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Randomised and directed bench for cam_pwr_seq against an elapsed-time model.
module tb_cam_pwr_seq;

  localparam int PCYC = 4;
  localparam int RCYC = 8;
  localparam int SCYC = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       seqStart;
  logic       seqPwdnReq;
  logic [1:0] camEn;
  logic [1:0] camPwdn;
  logic [1:0] camRstN;
  logic       seqBusy;
  logic       seqDone;

  logic       aRstN;
  logic       aStart;
  logic       aPwdnReq;
  logic [1:0] aEn;
  logic [1:0] aPwdn;
  logic [1:0] aRstNOut;
  logic       aBusy;
  logic       aDone;

  int total = 0;
  int bad   = 0;

  // Reference model: running flag, edges since the start edge, latched mask.
  bit         mRun;
  int         mK;
  logic [1:0] mMask;

  always #5 clk = ~clk;

  cam_pwr_seq #(
    .NUM_CAM    (2),
    .CNT_W      (8),
    .PWDN_CYC   (PCYC),
    .RST_CYC    (RCYC),
    .SETTLE_CYC (SCYC),
    .AUTO_START (0)
  ) dut (
    .s_axil_aclk   (clk),
    .s_axil_arst_n (rstN),
    .seq_start     (seqStart),
    .seq_pwdn_req  (seqPwdnReq),
    .cam_en        (camEn),
    .cam_pwdn      (camPwdn),
    .cam_rst_n     (camRstN),
    .seq_busy      (seqBusy),
    .seq_done      (seqDone)
  );

  cam_pwr_seq #(
    .NUM_CAM    (2),
    .CNT_W      (8),
    .PWDN_CYC   (PCYC),
    .RST_CYC    (RCYC),
    .SETTLE_CYC (SCYC),
    .AUTO_START (1)
  ) dutAuto (
    .s_axil_aclk   (clk),
    .s_axil_arst_n (aRstN),
    .seq_start     (aStart),
    .seq_pwdn_req  (aPwdnReq),
    .cam_en        (aEn),
    .cam_pwdn      (aPwdn),
    .cam_rst_n     (aRstNOut),
    .seq_busy      (aBusy),
    .seq_done      (aDone)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at a negedge, advance the model at the edge, check at the next negedge.
  task automatic applyStimulus(input logic st, input logic pd, input logic [1:0] en);
    logic [1:0] ePwdn;
    logic [1:0] eRstN;
    logic [1:0] invMask;
    seqStart   = st;
    seqPwdnReq = pd;
    camEn      = en;
    @(posedge clk);
    if (mRun) begin
      if (pd) mRun = 1'b0;
      else if (mK < 100000) mK++;
    end else if (st && !pd && en != 2'b00) begin
      mRun  = 1'b1;
      mK    = 1;
      mMask = en;
    end
    @(negedge clk);
    seqStart   = 1'b0;
    seqPwdnReq = 1'b0;
    invMask = ~mMask;
    ePwdn = (!mRun || mK <= PCYC) ? 2'b11 : invMask;
    eRstN = (!mRun || mK <= PCYC + RCYC) ? 2'b00 : mMask;
    checkOutput("model_pwdn", camPwdn, ePwdn);
    checkOutput("model_rstn", camRstN, eRstN);
    checkOutput("model_busy", seqBusy, (mRun && mK <= PCYC + RCYC + SCYC));
    checkOutput("model_done", seqDone, (mRun && mK > PCYC + RCYC + SCYC));
  endtask

  // Full start with timing landmarks; optional extra start while settling.
  task automatic runSequence(input logic [1:0] en, input bit lateStart, input string tag);
    logic [1:0] invEn;
    invEn = ~en;
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, en);
    checkOutput({tag, "_busy_c1"}, seqBusy, 1);
    for (int c = 2; c <= 32; c++) begin
      applyStimulus(lateStart && (c == 20), 1'b0, en);
      if (c == 4)  checkOutput({tag, "_pwdn_c4"},  camPwdn, 2'b11);
      if (c == 5)  checkOutput({tag, "_pwdn_c5"},  camPwdn, invEn);
      if (c == 12) checkOutput({tag, "_rstn_c12"}, camRstN, 2'b00);
      if (c == 13) checkOutput({tag, "_rstn_c13"}, camRstN, en);
      if (c == 28) checkOutput({tag, "_busy_c28"}, seqBusy, 1);
      if (c == 28) checkOutput({tag, "_done_c28"}, seqDone, 0);
      if (c == 29) checkOutput({tag, "_done_c29"}, seqDone, 1);
      if (c == 29) checkOutput({tag, "_busy_c29"}, seqBusy, 0);
      if (en[1] == 1'b0) checkOutput({tag, "_ch1_off"}, {camPwdn[1], camRstN[1]}, 2'b10);
    end
  endtask

  initial begin
    rstN = 1'b0; seqStart = 1'b0; seqPwdnReq = 1'b0; camEn = 2'b00;
    aRstN = 1'b0; aStart = 1'b0; aPwdnReq = 1'b0; aEn = 2'b00;
    mRun = 1'b0; mK = 0; mMask = 2'b00;

    #12;
    checkOutput("rst_pwdn", camPwdn, 2'b11);
    checkOutput("rst_rstn", camRstN, 2'b00);
    checkOutput("rst_busy", seqBusy, 0);
    checkOutput("rst_done", seqDone, 0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] start and partial-mask sequences");
    runSequence(2'b11, 1'b0, "start");
    runSequence(2'b01, 1'b0, "mask01");
    runSequence(2'b10, 1'b0, "mask10");

    $display("[TB] zero mask start is ignored");
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkOutput("zero_en_busy", seqBusy, 0);

    $display("[TB] abort mid-sequence");
    applyStimulus(1'b1, 1'b0, 2'b11);
    for (int c = 2; c <= 10; c++) applyStimulus(1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b11);
    checkOutput("abort_busy_c11", seqBusy, 0);
    checkOutput("abort_pwdn_c11", camPwdn, 2'b11);
    checkOutput("abort_rstn_c11", camRstN, 2'b00);
    runSequence(2'b11, 1'b0, "replay");

    $display("[TB] collisions");
    applyStimulus(1'b1, 1'b1, 2'b11);
    checkOutput("collide_done", seqDone, 0);
    checkOutput("collide_busy", seqBusy, 0);
    runSequence(2'b11, 1'b1, "settle_start");

    $display("[TB] asynchronous reset mid-sequence");
    applyStimulus(1'b0, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b11);
    for (int c = 2; c <= 7; c++) applyStimulus(1'b0, 1'b0, 2'b11);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_pwdn", camPwdn, 2'b11);
    checkOutput("arst_rstn", camRstN, 2'b00);
    checkOutput("arst_busy", seqBusy, 0);
    checkOutput("arst_done", seqDone, 0);
    mRun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b0, 2'b11);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)));
    end

    $display("[TB] auto-start instance");
    checkOutput("auto_rst_pwdn", aPwdn, 2'b11);
    checkOutput("auto_rst_busy", aBusy, 0);
    @(negedge clk);
    aRstN = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("auto_busy", aBusy, (c <= 28));
      checkOutput("auto_done", aDone, (c >= 29));
      checkOutput("auto_pwdn", aPwdn, (c <= 4) ? 2'b11 : 2'b00);
      checkOutput("auto_rstn", aRstNOut, (c <= 12) ? 2'b00 : 2'b11);
    end
    aPwdnReq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aPwdnReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checkOutput("auto_noretrig_busy", aBusy, 0);
      checkOutput("auto_noretrig_done", aDone, 0);
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_pwr_seq.md
CAM_PWR_SEQ -- requirements
Module: cam_pwr_seq

Interface
REQ-001 The block SHALL have parameter NUM_CAM, default 1: number of camera channels sequenced together (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32: timer width in bits.
REQ-003 The block SHALL have parameter PWDN_CYC, default 1_000_000: cycles PWDN stays high after start (>=1, < 2^CNT_W).
REQ-004 The block SHALL have parameter RST_CYC, default 100_000: cycles reset stays low after PWDN falls (>=1, < 2^CNT_W).
REQ-005 The block SHALL have parameter SETTLE_CYC, default 2_000_000: cycles from reset release to done (>=1, < 2^CNT_W).
REQ-006 The block SHALL have parameter AUTO_START, default 1: 1 starts the sequence on all channels automatically after reset.
REQ-007 The block SHALL have port s_axil_aclk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port s_axil_arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port seq_start, input, 1 bit: single-cycle power-up request.
REQ-010 The block SHALL have port seq_pwdn_req, input, 1 bit: single-cycle power-down request.
REQ-011 The block SHALL have port cam_en, input, NUM_CAM bits: channel enable mask, sampled at start.
REQ-012 The block SHALL have port cam_pwdn, output, NUM_CAM bits: per-camera power-down, active high.
REQ-013 The block SHALL have port cam_rst_n, output, NUM_CAM bits: per-camera reset, active low.
REQ-014 The block SHALL have port seq_busy, output, 1 bit: high in S_PWDN, S_RST and S_SETTLE.
REQ-015 The block SHALL have port seq_done, output, 1 bit: high in S_ON.

Function
REQ-016 The FSM SHALL have five states: S_OFF, S_PWDN, S_RST, S_SETTLE and S_ON.
REQ-017 In S_OFF, every channel SHALL drive pwdn=1 and rst_n=0.
REQ-018 In S_PWDN, every channel SHALL drive pwdn=1 and rst_n=0.
REQ-019 In S_RST, enabled channels SHALL drive pwdn=0 and rst_n=0.
REQ-020 In S_SETTLE and S_ON, enabled channels SHALL drive pwdn=0 and rst_n=1.
REQ-021 Disabled channels (mask bit 0) SHALL drive pwdn=1 and rst_n=0 in every state.
REQ-022 When seq_start=1 in S_OFF and cam_en!=0, the block SHALL latch cam_en into the mask register and enter S_PWDN on the next edge.
REQ-023 When seq_start=1 in S_OFF and cam_en==0, the request SHALL be ignored and the FSM SHALL stay in S_OFF.
REQ-024 seq_start SHALL be ignored in every state other than S_OFF.
REQ-025 S_PWDN, S_RST and S_SETTLE SHALL each last exactly PWDN_CYC, RST_CYC and SETTLE_CYC cycles respectively: the timer loads N-1 on entry and the FSM advances on the cycle the timer reads zero.
REQ-026 On timeout the FSM SHALL advance S_PWDN -> S_RST -> S_SETTLE -> S_ON; S_ON SHALL persist until seq_pwdn_req.
REQ-027 seq_pwdn_req=1 in any state other than S_OFF SHALL force S_OFF on the next edge and clear the timer.
REQ-028 seq_pwdn_req SHALL win when it is asserted in the same cycle as seq_start.
REQ-029 All outputs SHALL be a decode of the state register and mask register, with no extra pipeline stage, so each output changes on the edge that changes state.
REQ-030 The timer SHALL never wrap; a zero-count read in a state other than S_PWDN, S_RST or S_SETTLE SHALL cause no transition.
REQ-031 With AUTO_START=1, the first clock after reset deassertion SHALL behave as seq_start=1 with cam_en = all ones, exactly once per reset.
REQ-032 Parameter values that violate their stated ranges SHALL be rejected at elaboration by an assertion.

Reset
REQ-033 Asserting s_axil_arst_n low SHALL asynchronously force, at any time including mid-sequence: state=S_OFF, timer=0, mask=0, cam_pwdn=all ones, cam_rst_n=all zeros, seq_busy=0, seq_done=0.
REQ-034 Deassertion of s_axil_arst_n SHALL be synchronised externally; the block SHALL assume synchronous release.

Structure
REQ-035 Package cam_pwr_pkg SHALL hold the state enum (S_OFF..S_ON) and the default cycle constants used by the ov5640 shell.
REQ-036 The block SHALL contain one sub-module, cam_pwr_timer: a CNT_W-bit loadable down-counter with load, clear and zero-flag ports.

Verification (NUM_CAM=2, PWDN_CYC=4, RST_CYC=8, SETTLE_CYC=16, AUTO_START=0)
REQ-037 Start test: seq_start pulse at cycle 0 with cam_en=2'b11 -> cam_pwdn falls at cycle 5, cam_rst_n rises at cycle 13, seq_done rises at cycle 29, and seq_busy is high over cycles 1-28.
REQ-038 Partial mask test: cam_en=2'b01 at start -> channel 1 holds pwdn=1 and rst_n=0 throughout, while channel 0 follows the REQ-037 timing.
REQ-039 Abort test: seq_pwdn_req at cycle 10 of a sequence -> S_OFF at cycle 11 with outputs at their off values; a new start then replays the full REQ-037 timing.
REQ-040 Collision test: seq_start and seq_pwdn_req together in S_ON -> S_OFF; seq_start alone in S_SETTLE -> ignored and done still at cycle 29.
REQ-041 Mid-sequence reset test: s_axil_arst_n low at cycle 7 -> outputs return to reset values within the same cycle (asynchronously) and no seq_done afterwards without a new start.
REQ-042 Auto-start test: AUTO_START=1 -> sequence runs once after reset release, seq_done at cycle 29, with no re-trigger.
